// File: rtl/sp1_ram2p_pkg.sv
// Shared constants and types for the sp1_ram2p simple-dual-port RAM.
// Read-during-write mode selectors and clear-sequencer state encoding.
package sp1_ram2p_pkg;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

  typedef enum logic {
    ClrStClear = 1'b0,
    ClrStReady = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sp1_ram2p_clr.sv
// Post-reset clear sequencer: walks every address once, writing zero, while busy is held high.
module sp1_ram2p_clr
  import sp1_ram2p_pkg::*;
#(
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_en,
  output logic [AW-1:0] clr_adr
);

  localparam logic [AW-1:0] LastAdr = {AW{1'b1}};

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ClrStClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    clr_adr = cnt_q;
    unique case (state_q)
      ClrStClear: begin
        // No clearing while rst is still held; the first write happens after release.
        if (!rst) begin
          clr_en = 1'b1;
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q == LastAdr) begin
            state_d = ClrStReady;
          end
        end
      end
      ClrStReady: begin
        state_d = ClrStReady;
      end
    endcase
  end

  assign busy = (state_q == ClrStClear);

endmodule

// File: rtl/sp1_ram2p.sv
// Simple-dual-port synchronous RAM: byte-enabled write port, independent registered read port
// with valid flag, selectable read-during-write behaviour and optional output register.
module sp1_ram2p
  import sp1_ram2p_pkg::*;
#(
  parameter int unsigned AW       = 6,
  parameter int unsigned DW       = 32,
  parameter int unsigned BW       = 8,
  parameter int unsigned OREG     = 0,
  parameter int unsigned RDW_MODE = 0,
  parameter int unsigned INIT_CLR = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  input  logic             wcs,
  input  logic [AW-1:0]    wadr,
  input  logic [DW/BW-1:0] wbe,
  input  logic [DW-1:0]    wdin,
  input  logic             rcs,
  input  logic [AW-1:0]    radr,
  output logic [DW-1:0]    dout,
  output logic             dvalid
);

  localparam int unsigned DS = 1 << AW;
  localparam int unsigned NB = DW / BW;

  if ((DW % BW) != 0) begin : g_bad_width
    $error("sp1_ram2p: DW must be a multiple of BW");
  end

  logic [DW-1:0] mem_q [DS];

  logic          clr_en;
  logic [AW-1:0] clr_adr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          s1_valid_q;
  logic [DW-1:0] s1_data_q;

  if (INIT_CLR != 0) begin : g_clr
    sp1_ram2p_clr #(
      .AW(AW)
    ) u_clr (
      .clk    (clk),
      .rst    (rst),
      .busy   (busy),
      .clr_en (clr_en),
      .clr_adr(clr_adr)
    );
  end else begin : g_no_clr
    assign busy    = 1'b0;
    assign clr_en  = 1'b0;
    assign clr_adr = '0;
  end

  assign wr_en = wcs & ~busy;
  assign rd_en = rcs & ~busy;

  // Array is deliberately not reset; only the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem_q[clr_adr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wbe[i]) begin
          mem_q[wadr][i*BW +: BW] <= wdin[i*BW +: BW];
        end
      end
    end
  end

  // Old data falls out naturally from the array read; new-data mode overlays written lanes.
  always_comb begin
    rd_data = mem_q[radr];
    if ((RDW_MODE == RDW_NEW) && wr_en && (wadr == radr)) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (wbe[i]) begin
          rd_data[i*BW +: BW] = wdin[i*BW +: BW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      if (rd_en) begin
        s1_data_q <= rd_data;
      end
    end
  end

  if (OREG != 0) begin : g_oreg
    logic          s2_valid_q;
    logic [DW-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign dout   = s2_data_q;
    assign dvalid = s2_valid_q;
  end else begin : g_no_oreg
    assign dout   = s1_data_q;
    assign dvalid = s1_valid_q;
  end

`ifndef SYNTH
  always @(posedge clk) begin
    if (wcs && !busy && ($isunknown(wadr) || $isunknown(wbe) || $isunknown(wdin))) begin
      $display("%0t %m: warning: unknown value on write port", $time);
    end
    if (rcs && !busy && $isunknown(radr)) begin
      $display("%0t %m: warning: unknown value on read address", $time);
    end
  end
`endif

endmodule

// File: tb/tb_sp1_ram2p.sv
// Scoreboard bench for sp1_ram2p: two configurations (latency 1 / old-data and latency 2 /
// new-data) driven by the same stimulus and checked against an array-based reference model.
module tb_sp1_ram2p;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wcs = 1'b0;
  logic [3:0]  wadr = '0;
  logic [3:0]  wbe = '0;
  logic [31:0] wdin = '0;
  logic        rcs = 1'b0;
  logic [3:0]  radr = '0;

  logic        busy0, busy1, dvalid0, dvalid1;
  logic [31:0] dout0, dout1;

  sp1_ram2p #(
    .AW(4), .DW(32), .BW(8), .OREG(0), .RDW_MODE(0), .INIT_CLR(1)
  ) dut0 (
    .clk(clk), .rst(rst), .busy(busy0), .wcs(wcs), .wadr(wadr), .wbe(wbe), .wdin(wdin),
    .rcs(rcs), .radr(radr), .dout(dout0), .dvalid(dvalid0)
  );

  sp1_ram2p #(
    .AW(4), .DW(32), .BW(8), .OREG(1), .RDW_MODE(1), .INIT_CLR(1)
  ) dut1 (
    .clk(clk), .rst(rst), .busy(busy1), .wcs(wcs), .wadr(wadr), .wbe(wbe), .wdin(wdin),
    .rcs(rcs), .radr(radr), .dout(dout1), .dvalid(dvalid1)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] model_mem [16];
  int          busy_left = 16;
  logic        exp_busy = 1'b1;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;
  exp_t        q0[$];
  exp_t        q1[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, req);
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
    return r;
  endfunction

  // Drive one cycle of stimulus and advance the model to the state after the coming edge.
  task automatic step(input logic r, input logic w, input logic [3:0] wa, input logic [3:0] be,
                      input logic [31:0] wd, input logic rd, input logic [3:0] ra);
    exp_t        e;
    logic [31:0] old;
    @(negedge clk);
    rst = r; wcs = w; wadr = wa; wbe = be; wdin = wd; rcs = rd; radr = ra;
    if (r) begin
      busy_left = 16;
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (busy_left > 0) begin
      model_mem[16 - busy_left] = '0;
      busy_left--;
    end else begin
      if (rd) begin
        old    = model_mem[ra];
        e.data = old;
        e.cyc  = cyc + 1;
        q0.push_back(e);
        e.data = (w && wa == ra) ? merge(old, wd, be) : old;
        e.cyc  = cyc + 2;
        q1.push_back(e);
      end
      if (w) model_mem[wa] = merge(model_mem[wa], wd, be);
    end
    exp_busy = (busy_left > 0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic mon(input int k, input logic dv, input logic [31:0] dd);
    exp_t e;
    logic have;
    have = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (k == 0) ? q0[0] : q1[0];
    if (dv) begin
      if (!have) begin
        checks++;
        $display("FAIL dvalid%0d at cycle %0d: got dvalid 1, required 0", k, cyc);
      end else begin
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
        chk($sformatf("dout%0d", k), dd, e.data);
        chk($sformatf("latency%0d", k), cyc, e.cyc);
        if (k == 0) last0 = e.data;
        else last1 = e.data;
      end
    end else begin
      if (have && e.cyc <= cyc) begin
        checks++;
        $display("FAIL missing%0d at cycle %0d: got dvalid 0, required 1", k, cyc);
        if (k == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end
      chk($sformatf("hold%0d", k), dd, (k == 0) ? last0 : last1);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("busy0", {31'h0, busy0}, {31'h0, exp_busy});
      chk("busy1", {31'h0, busy1}, {31'h0, exp_busy});
      mon(0, dvalid0, dout0);
      mon(1, dvalid1, dout1);
    end
  end

  initial begin
    // Two-cycle reset, then port activity during the clear that must be ignored.
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'h9, 4'hF, 32'hDEADBEEF, 1'b1, 4'(i));
    idle();
    // Every address must read back zero.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
    idle();
    // Byte-lane merge.
    step(1'b0, 1'b1, 4'h3, 4'hF, 32'hAABBCCDD, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h3, 4'h5, 32'h11223344, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3);
    // Same-address read during write.
    step(1'b0, 1'b1, 4'h5, 4'h3, 32'hFFFFFFFF, 1'b1, 4'h5);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h5);
    // Back-to-back reads.
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 4'(i), 4'hF, 32'(i), 1'b0, 4'h0);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(i));
    repeat (3) idle();
    // Randomised traffic with frequent address collisions.
    for (int n = 0; n < 300; n++) begin
      logic [3:0] wa;
      wa = 4'($urandom);
      step(1'b0, 1'($urandom), wa, 4'($urandom), $urandom, 1'($urandom),
           ($urandom_range(0, 3) == 0) ? wa : 4'($urandom));
    end
    // Reset with reads in flight, then reset again part-way through the clear.
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h4);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'(i), 4'hF, $urandom, 1'b1, 4'(i));
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'($urandom), 4'($urandom), 4'hF, $urandom, 1'b1, 4'(i));
    for (int n = 0; n < 40; n++)
      step(1'b0, 1'($urandom), 4'($urandom), 4'($urandom), $urandom, 1'($urandom), 4'($urandom));
    repeat (4) idle();
    chk("drain0", q0.size(), 32'd0);
    chk("drain1", q1.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
